// File: rtl/dot_product_pkg.sv
// dot_product_pkg
//   Shared definitions for the sequential dot-product engine.
//   - state_t      : control FSM states (ACC, FLUSH, HOLD)
//   - acc_width()  : full-precision accumulator width for a given element
//                    width and vector length (2*data_w + clog2(len))
//   - DATA_W_DEF / LEN_DEF : default element width and vector length
package dot_product_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned LEN_DEF    = 4;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned len);
      return 2 * data_w + $clog2(len);
   endfunction

endpackage

// File: rtl/dot_product_mac.sv
// dot_product_mac
//   Registered multiply stage followed by a full-precision accumulator.
//   Build option: DOT_PRODUCT_SIGNED_EN selects two's-complement operands,
//   products and accumulation; otherwise everything is unsigned.
//
//   Ports:
//     clk  in            rising-edge clock
//     rst  in            asynchronous active-high reset
//     clr  in            synchronous accumulator clear (result consumed)
//     en   in            accept a, b into the product register this edge
//     a    in  DATA_W    element a_i
//     b    in  DATA_W    element b_i
//     acc  out ACC_W     running sum of all registered products
module dot_product_mac #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned EXT_W  = ACC_W - PROD_W;

`ifdef DOT_PRODUCT_SIGNED_EN
   localparam logic SIGNED_MODE = 1'b1;
`else
   localparam logic SIGNED_MODE = 1'b0;
`endif

   logic              sign_a;
   logic              sign_b;
   logic              sign_p;
   logic [PROD_W-1:0] wide_a;
   logic [PROD_W-1:0] wide_b;
   logic [PROD_W-1:0] prod_next;
   logic [PROD_W-1:0] prod_reg;
   logic              prod_vld;
   logic [ACC_W-1:0]  prod_ext;

   // Operands are widened to the full product width (sign- or zero-filled)
   // so a single unsigned multiplier, truncated to PROD_W bits, yields the
   // exact product in either signedness.
   assign sign_a    = SIGNED_MODE & a[DATA_W-1];
   assign sign_b    = SIGNED_MODE & b[DATA_W-1];
   assign wide_a    = {{DATA_W{sign_a}}, a};
   assign wide_b    = {{DATA_W{sign_b}}, b};
   assign prod_next = wide_a * wide_b;

   assign sign_p    = SIGNED_MODE & prod_reg[PROD_W-1];
   assign prod_ext  = {{EXT_W{sign_p}}, prod_reg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_reg <= '0;
         prod_vld <= 1'b0;
         acc      <= '0;
      end else begin
         prod_vld <= en;
         if (en) begin
            prod_reg <= prod_next;
         end
         // clr only occurs while the result is held, when no product is
         // pending, so giving it priority never drops a product.
         if (clr) begin
            acc <= '0;
         end else if (prod_vld) begin
            acc <= acc + prod_ext;
         end
      end
   end

endmodule

// File: rtl/dot_product_seq.sv
// dot_product_seq
//   Sequential dot-product engine: one (a_i, b_i) pair per valid/ready
//   beat, registered product, full-precision accumulate; after LEN beats
//   the sum is offered on a valid/ready output port.
//   Build option: DOT_PRODUCT_SIGNED_EN (two's-complement arithmetic).
//
//   Parameters: DATA_W (element width), LEN (elements per vector, >= 2),
//               ACC_W (derived, not overridable).
//   Ports:
//     clk        in            rising-edge clock
//     rst        in            asynchronous active-high reset
//     in_valid   in            element pair valid
//     in_ready   out           engine can accept a pair
//     a_in       in  DATA_W    element a_i
//     b_in       in  DATA_W    element b_i
//     out_valid  out           result valid
//     out_ready  in            downstream accepts result
//     result     out ACC_W     dot product
//     busy       out           vector in progress or result pending
module dot_product_seq
   import dot_product_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned LEN    = LEN_DEF,
   localparam int unsigned ACC_W  = acc_width(DATA_W, LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  result,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(LEN);

   if (LEN < 2) begin : g_len_check
      $error("dot_product_seq: LEN must be at least 2");
   end

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             beat;
   logic             last_beat;
   logic             handshake;

   assign beat      = in_valid && in_ready;
   assign last_beat = (cnt == CNT_W'(LEN - 1));
   assign handshake = out_valid && out_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         ACC:     if (beat && last_beat) state_next = FLUSH;
         FLUSH:   state_next = HOLD;
         HOLD:    if (out_ready) state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   // Outputs decode registered state only, keeping in_* -> out_* paths
   // purely sequential.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (cnt != '0);
      unique case (state)
         ACC:     in_ready  = 1'b1;
         FLUSH:   busy      = 1'b1;
         HOLD: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b0;
      endcase
   end

   // Beat counter; wraps on the LEN-th accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (beat) begin
         cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
   end

   dot_product_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (handshake),
      .en  (beat),
      .a   (a_in),
      .b   (b_in),
      .acc (result)
   );

   a_no_overlap: assert property (@(posedge clk) disable iff (rst)
      !(in_ready && out_valid));
   a_flush_one_cycle: assert property (@(posedge clk) disable iff (rst)
      (state == FLUSH) |=> (state == HOLD));
   a_result_stable: assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(result)));

endmodule

// File: tb/tb_dot_product_seq.sv
module tb_dot_product_seq;

   localparam int DW    = 8;
   localparam int LEN   = 4;
   localparam int ACC_W = 2 * DW + $clog2(LEN);

`ifdef DOT_PRODUCT_SIGNED_EN
   localparam logic [ACC_W-1:0] EXP_EXT = 18'd4;
   localparam logic [ACC_W-1:0] EXP_MIX = 18'h3FFFA;
`else
   localparam logic [ACC_W-1:0] EXP_EXT = 18'd260100;
   localparam logic [ACC_W-1:0] EXP_MIX = 18'd3578;
`endif

   typedef struct packed {
      logic [3:0][7:0]  a;
      logic [3:0][7:0]  b;
      logic             gap;
      logic [3:0]       hold;
      logic [ACC_W-1:0] exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DW-1:0]    a_in = '0;
   logic [DW-1:0]    b_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] result;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [ACC_W-1:0] sb[$];
   int               hs_q[$];

   dot_product_seq #(
      .DATA_W (DW),
      .LEN    (LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: each result handshake pops the oldest expected value.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0d expected no output", result);
         end else begin
            chk("result", result, sb.pop_front());
         end
         hs_q.push_back(cyc + 1);
      end
   end

   task automatic send_beat(input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
      int g;
      g = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) chk("beat_timeout", 0, 1);
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input vec_t v, output int first_cyc);
      int c;
      first_cyc = 0;
      for (int i = 0; i < LEN; i++) begin
         send_beat(v.a[i], v.b[i], c);
         if (i == 0) begin
            first_cyc = c;
            chk("busy_mid_vector", busy, 1);
         end
         if (v.gap && i < LEN - 1) begin
            @(negedge clk);
            chk("cnt_hold_gap_busy", busy, 1);
         end
      end
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      chk("out_valid_latency", out_valid, 1);
      chk("hold_result", result, v.exp);
   endtask

   task automatic wait_drain();
      for (int g = 0; g < 20 && sb.size() != 0; g++) begin
         @(posedge clk);
         #2;
      end
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic gap, input logic [3:0] hold,
                               input logic [ACC_W-1:0] exp);
      vec_t v;
      v.a    = a;
      v.b    = b;
      v.gap  = gap;
      v.hold = hold;
      v.exp  = exp;
      return v;
   endfunction

   initial begin
      vec_t tbl[5];
      int   f1, f2, dummy;

      tbl[0] = mk(32'h04030201, 32'h08070605, 1'b0, 4'd0, 18'd70);
      tbl[1] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd0, EXP_EXT);
      tbl[2] = mk(32'h04030201, 32'h08070605, 1'b1, 4'd5, 18'd70);
      tbl[3] = mk(32'h01010101, 32'h02020202, 1'b0, 4'd0, 18'd8);
      tbl[4] = mk(32'h0403FEFF, 32'h08F90605, 1'b0, 4'd2, EXP_MIX);

      repeat (3) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;

      for (int t = 0; t < 5; t++) begin
         out_ready = (tbl[t].hold == 0);
         sb.push_back(tbl[t].exp);
         send_vec(tbl[t], dummy);
         for (int k = 0; k < int'(tbl[t].hold); k++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_stable_result", result, tbl[t].exp);
         end
         out_ready = 1'b1;
         wait_drain();
      end

      // Back-to-back vectors with out_ready tied high.
      out_ready = 1'b1;
      hs_q.delete();
      sb.push_back(18'd70);
      send_vec(tbl[0], f1);
      sb.push_back(18'd8);
      send_vec(tbl[3], f2);
      if (hs_q.size() == 0) begin
         chk("b2b_first_handshake_seen", 0, 1);
      end else begin
         chk("b2b_next_beat_after_handshake", f2, hs_q[0] + 1);
      end
      chk("b2b_vector_period", f2 - f1, LEN + 2);
      wait_drain();

      // Reset mid-vector: partial sum must vanish and no result appear.
      send_beat(8'd1, 8'd5, dummy);
      send_beat(8'd2, 8'd6, dummy);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_result", result, 0);
      chk("async_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(18'd70);
      send_vec(tbl[0], dummy);
      wait_drain();
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
